// File: rtl/aes16_pkg.sv
// Shared S-AES helpers for the 16-bit decryption core: nibble S-boxes, GF(2^4)
// constant multipliers, key-schedule round constants and the FSM state type.
package aes16_pkg;

    localparam logic [7:0] RCON1 = 8'h80;
    localparam logic [7:0] RCON2 = 8'h30;

    typedef enum logic [2:0] {IDLE, KEYX, RND2, RND1, FIN} state_t;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] r;
        r = 4'h0;
        case (x)
            4'h0: r = 4'h9;  4'h1: r = 4'h4;  4'h2: r = 4'hA;  4'h3: r = 4'hB;
            4'h4: r = 4'hD;  4'h5: r = 4'h1;  4'h6: r = 4'h8;  4'h7: r = 4'h5;
            4'h8: r = 4'h6;  4'h9: r = 4'h2;  4'hA: r = 4'h0;  4'hB: r = 4'h3;
            4'hC: r = 4'hC;  4'hD: r = 4'hE;  4'hE: r = 4'hF;  4'hF: r = 4'h7;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
        logic [3:0] r;
        r = 4'h0;
        case (x)
            4'h0: r = 4'hA;  4'h1: r = 4'h5;  4'h2: r = 4'h9;  4'h3: r = 4'hB;
            4'h4: r = 4'h1;  4'h5: r = 4'h7;  4'h6: r = 4'h8;  4'h7: r = 4'hF;
            4'h8: r = 4'h6;  4'h9: r = 4'h0;  4'hA: r = 4'h2;  4'hB: r = 4'h3;
            4'hC: r = 4'hC;  4'hD: r = 4'h4;  4'hE: r = 4'hD;  4'hF: r = 4'hE;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    // Multiply by x modulo x^4+x+1: shift left, fold the carry back in as 4'h3.
    function automatic logic [3:0] gf16_mul2(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [3:0] gf16_mul9(input logic [3:0] a);
        return gf16_mul2(gf16_mul2(gf16_mul2(a))) ^ a;
    endfunction

    // SubNib(RotNib(w)) used by the key schedule.
    function automatic logic [7:0] sub_rot(input logic [7:0] w);
        return {sbox4(w[3:0]), sbox4(w[7:4])};
    endfunction

endpackage

// File: rtl/aes16_key_expand.sv
// Combinational S-AES key schedule: one 16-bit key to the three round keys.
module aes16_key_expand
    import aes16_pkg::*;
(
    input  logic [15:0] i_key,
    output logic [15:0] o_k0,
    output logic [15:0] o_k1,
    output logic [15:0] o_k2
);

    logic [7:0] w_w2;
    logic [7:0] w_w3;
    logic [7:0] w_w4;
    logic [7:0] w_w5;

    assign w_w2 = i_key[15:8] ^ RCON1 ^ sub_rot(i_key[7:0]);
    assign w_w3 = w_w2 ^ i_key[7:0];
    assign w_w4 = w_w2 ^ RCON2 ^ sub_rot(w_w3);
    assign w_w5 = w_w4 ^ w_w3;

    assign o_k0 = i_key;
    assign o_k1 = {w_w2, w_w3};
    assign o_k2 = {w_w4, w_w5};

endmodule

// File: rtl/aes16_decr_core.sv
// Iterative S-AES decryptor: key expansion, two inverse rounds, result 4 cycles
// after start. `define AES_DECR_LOCK_EN adds the unlock gate on start.
module aes16_decr_core
    import aes16_pkg::*;
#(
    parameter bit          KEY_FIXED = 1'b0,
    parameter logic [15:0] KEY_VALUE = 16'hA73B
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        start,
`ifdef AES_DECR_LOCK_EN
    input  logic        unlock,
`endif
    input  logic [15:0] ctext,
    input  logic [15:0] key,
    output logic [15:0] ptext,
    output logic        busy,
    output logic        done
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_st;
    logic [15:0] r_kreg;
    logic [15:0] r_k0;
    logic [15:0] r_k1;
    logic [15:0] r_k2;
    logic [15:0] r_ptext;
    logic        r_done;
    logic        w_accept;
    logic [15:0] w_k0;
    logic [15:0] w_k1;
    logic [15:0] w_k2;
    logic [15:0] w_x1;
    logic [15:0] w_mix;
    logic [15:0] w_rnd2;
    logic [15:0] w_rnd1;

`ifdef AES_DECR_LOCK_EN
    assign w_accept = start & unlock;
`else
    assign w_accept = start;
`endif

    // InvShiftRows (swap n1/n3) followed by InvSubNibbles.
    function automatic logic [15:0] inv_shift_sub(input logic [15:0] s);
        return {inv_sbox4(s[15:12]), inv_sbox4(s[3:0]),
                inv_sbox4(s[7:4]),   inv_sbox4(s[11:8])};
    endfunction

    aes16_key_expand u_key_expand (
        .i_key (r_kreg),
        .o_k0  (w_k0),
        .o_k1  (w_k1),
        .o_k2  (w_k2)
    );

    assign w_x1   = r_st ^ r_k1;
    assign w_mix  = {gf16_mul9(w_x1[15:12]) ^ gf16_mul2(w_x1[11:8]),
                     gf16_mul2(w_x1[15:12]) ^ gf16_mul9(w_x1[11:8]),
                     gf16_mul9(w_x1[7:4])   ^ gf16_mul2(w_x1[3:0]),
                     gf16_mul2(w_x1[7:4])   ^ gf16_mul9(w_x1[3:0])};
    assign w_rnd2 = inv_shift_sub(r_st ^ r_k2);
    assign w_rnd1 = inv_shift_sub(w_mix);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // NOTE: w_next gets its default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = KEYX;
            KEYX:    w_next = RND2;
            RND2:    w_next = RND1;
            RND1:    w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: all datapath registers are cleared on reset so an aborted run leaves no stale key or state.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_st    <= 16'h0000;
            r_kreg  <= 16'h0000;
            r_k0    <= 16'h0000;
            r_k1    <= 16'h0000;
            r_k2    <= 16'h0000;
            r_ptext <= 16'h0000;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_st   <= ctext;
                    r_kreg <= KEY_FIXED ? KEY_VALUE : key;
                end
                KEYX: begin
                    r_k0 <= w_k0;
                    r_k1 <= w_k1;
                    r_k2 <= w_k2;
                end
                RND2: r_st <= w_rnd2;
                RND1: r_st <= w_rnd1;
                FIN: begin
                    r_ptext <= r_st ^ r_k0;
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ptext = r_ptext;
    assign done  = r_done;
    assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_aes16_decr_core.sv
// Self-checking bench for aes16_decr_core: vector table, random ops against a
// nibble-level S-AES model, and hand-written multi-cycle corner sequences.
module tb_aes16_decr_core;

    logic        clkin = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        unlock = 1'b1;
    logic [15:0] ctext = 16'h0000;
    logic [15:0] key = 16'h0000;
    logic [15:0] ptext;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    always #5 clkin = ~clkin;

    aes16_decr_core dut (
        .clkin (clkin),
        .reset (reset),
        .start (start),
`ifdef AES_DECR_LOCK_EN
        .unlock(unlock),
`endif
        .ctext (ctext),
        .key   (key),
        .ptext (ptext),
        .busy  (busy),
        .done  (done)
    );

    // ---------------- reference model ----------------
    localparam logic [3:0] SBOX [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                         4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};

    function automatic logic [3:0] m_inv_sbox(input logic [3:0] x);
        logic [3:0] r = 4'h0;
        for (int j = 0; j < 16; j++) if (SBOX[j] == x) r = 4'(j);
        return r;
    endfunction

    function automatic logic [3:0] m_gmul(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] aa = {1'b0, a};
        logic [3:0] p = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa[3:0];
            aa = aa << 1;
            if (aa[4]) aa = aa ^ 5'b10011;
        end
        return p;
    endfunction

    function automatic logic [7:0] m_g(input logic [7:0] w, input logic [7:0] rc);
        return rc ^ {SBOX[w[3:0]], SBOX[w[7:4]]};
    endfunction

    function automatic logic [15:0] m_decrypt(input logic [15:0] ct, input logic [15:0] k);
        logic [7:0]  w[6];
        logic [15:0] rk[3];
        logic [3:0]  n[4];
        logic [3:0]  t;
        logic [15:0] s;
        w[0] = k[15:8]; w[1] = k[7:0];
        w[2] = w[0] ^ m_g(w[1], 8'h80); w[3] = w[2] ^ w[1];
        w[4] = w[2] ^ m_g(w[3], 8'h30); w[5] = w[4] ^ w[3];
        for (int r = 0; r < 3; r++) rk[r] = {w[2*r], w[2*r+1]};
        s = ct;
        for (int r = 2; r >= 1; r--) begin
            s = s ^ rk[r];
            for (int i = 0; i < 4; i++) n[i] = s[15-4*i -: 4];
            if (r == 1) begin
                for (int c = 0; c < 2; c++) begin
                    t        = m_gmul(4'h9, n[2*c]) ^ m_gmul(4'h2, n[2*c+1]);
                    n[2*c+1] = m_gmul(4'h2, n[2*c]) ^ m_gmul(4'h9, n[2*c+1]);
                    n[2*c]   = t;
                end
            end
            t = n[1]; n[1] = n[3]; n[3] = t;
            for (int i = 0; i < 4; i++) n[i] = m_inv_sbox(n[i]);
            s = {n[0], n[1], n[2], n[3]};
        end
        return s ^ rk[0];
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    // Wait for done after the start-sampling edge; lat = edges since that edge.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input logic [15:0] ct, input logic [15:0] k,
                         input logic [15:0] exp, input string nm);
        int lat;
        int extra;
        ctext = ct; key = k; start = 1'b1;
        tick();
        start = 1'b0;
        check({nm, " busy_after_start"}, 16'(busy), 16'h1);
        wait_done(lat);
        check({nm, " latency"}, 16'(lat), 16'd4);
        check({nm, " ptext"}, ptext, exp);
        count_done(3, extra);
        check({nm, " single_done"}, 16'(extra), 16'd0);
        check({nm, " idle_busy"}, 16'(busy), 16'h0);
    endtask

    typedef struct {
        logic [15:0] ct;
        logic [15:0] k;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int cnt;
        int lat;
        logic [15:0] rct;
        logic [15:0] rk;

        vecs[0] = '{16'h0738, 16'hA73B, 16'h6F6B};
        vecs[1] = '{16'h24EC, 16'h4AF5, 16'hD728};
        for (int i = 2; i < 8; i++) begin
            vecs[i].ct  = 16'($urandom);
            vecs[i].k   = 16'($urandom);
            vecs[i].exp = m_decrypt(vecs[i].ct, vecs[i].k);
        end

        // Reset state and quiet idle period.
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset ptext", ptext, 16'h0000);
        check("reset done", 16'(done), 16'h0);
        check("reset busy", 16'(busy), 16'h0);
        count_done(20, cnt);
        check("idle no_done", 16'(cnt), 16'd0);

`ifdef AES_DECR_LOCK_EN
        unlock = 1'b0; ctext = 16'h0738; key = 16'hA73B; start = 1'b1;
        tick();
        start = 1'b0;
        check("locked busy", 16'(busy), 16'h0);
        count_done(8, cnt);
        check("locked no_done", 16'(cnt), 16'd0);
        check("locked ptext", ptext, 16'h0000);
        unlock = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; unlock = 1'b0;
        wait_done(lat);
        check("unlock drop latency", 16'(lat), 16'd4);
        check("unlock drop ptext", ptext, 16'h6F6B);
        unlock = 1'b1;
        tick();
`endif

        for (int i = 0; i < 8; i++) do_op(vecs[i].ct, vecs[i].k, vecs[i].exp, $sformatf("vec%0d", i));

        // Starts while busy are ignored; inputs changed after acceptance.
        ctext = 16'h0738; key = 16'hA73B; start = 1'b1;
        tick();
        ctext = 16'hFFFF; key = 16'h0000;
        tick();
        tick();
        start = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check("busy_start latency", 16'(lat), 16'd4);
        check("busy_start ptext", ptext, 16'h6F6B);
        count_done(10, cnt);
        check("busy_start single_done", 16'(cnt), 16'd0);

        // Reset while in RND1 aborts without a done pulse.
        ctext = 16'h0738; key = 16'hA73B; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("abort busy", 16'(busy), 16'h0);
        check("abort ptext", ptext, 16'h0000);
        check("abort done", 16'(done), 16'h0);
        tick();
        reset = 1'b0;
        count_done(10, cnt);
        check("abort no_done", 16'(cnt), 16'd0);
        do_op(16'h0738, 16'hA73B, 16'h6F6B, "after_abort");

        // Back-to-back: start asserted in the done cycle.
        ctext = 16'h0738; key = 16'hA73B; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        check("b2b first latency", 16'(lat), 16'd4);
        check("b2b first ptext", ptext, 16'h6F6B);
        ctext = 16'h24EC; key = 16'h4AF5; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b second spacing", 16'(lat), 16'd5);
        check("b2b second ptext", ptext, 16'hD728);
        tick();

        // Random operations against the model.
        for (int i = 0; i < 20; i++) begin
            rct = 16'($urandom);
            rk  = 16'($urandom);
            do_op(rct, rk, m_decrypt(rct, rk), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes16_decr_core.md
Name: aes16_decr_core

Overview:
Iterative 16-bit Simplified-AES (S-AES) decryption engine. It is the inverse of the encryption path feeding the password-detection stage. It accepts a 16-bit ciphertext and a 16-bit key on a start pulse, then runs key expansion and two inverse rounds over several cycles. It returns the plaintext with a one-cycle done pulse, and its output feeds the decrypted-digit display path.

Parameters:
KEY_FIXED, 0, 1 = ignore key input and use KEY_VALUE; 0 = use key port
KEY_VALUE, 16'hA73B, fixed key used when KEY_FIXED=1

Ports:
clkin  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
ctext  input  16  ciphertext, latched when start is accepted
key  input  16  cipher key, latched when start is accepted
ptext  output  16  decrypted plaintext, registered, held until the next completion
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse when ptext updates
unlock  input  1  present only with AES_DECR_LOCK_EN (see Optional Feature)

Behaviour:
- Reset (async, active-high): state=IDLE, ptext=16'h0000, done=0, busy=0, internal regs cleared. Asserting reset mid-operation aborts immediately; no done pulse is produced.
- Nibble order: n0=[15:12], n1=[11:8], n2=[7:4], n3=[3:0]. Column0={n0,n1}, column1={n2,n3}.
- Key expansion (S-AES):
  - w0=key[15:8], w1=key[7:0]
  - w2=w0^8'h80^SubNib(RotNib(w1)); w3=w2^w1
  - w4=w2^8'h30^SubNib(RotNib(w3)); w5=w4^w3
  - K0={w0,w1}, K1={w2,w3}, K2={w4,w5}
  - RotNib swaps the two nibbles. SubNib uses the forward S-box.
- Inverse S-box, index 0..F: A,5,9,B,1,7,8,F,6,0,2,3,C,4,D,E.
- InvShiftRows swaps n1 and n3.
- InvMixColumns: per column {a,b} -> {9a^2b, 2a^9b} in GF(2^4), polynomial x^4+x+1.
- FSM states and transitions:
  - IDLE: start=1 at edge N latches ctext/key into st/kreg and goes to KEYX.
  - KEYX (edge N+1): register K0/K1/K2, go to RND2.
  - RND2 (N+2): st=InvSub(InvShift(st^K2)), go to RND1.
  - RND1 (N+3): st=InvSub(InvShift(InvMix(st^K1))), go to FIN.
  - FIN (N+4): ptext<=st^K0, done<=1, go to IDLE.
- Latency: done and the new ptext are visible 4 cycles after the start-sampling edge.
- done is high for exactly one cycle. busy is high in KEYX, RND2, RND1 and FIN.
- start while busy is ignored; no queuing.
- start in the cycle done is high (state is IDLE) is accepted, giving back-to-back operation at one result per 5 cycles.
- ctext/key changes after acceptance do not affect the running operation.
- KEY_FIXED=1: the key port is unused and KEY_VALUE is latched instead.

Optional Feature:
- Macro: AES_DECR_LOCK_EN.
- Defined: the unlock port exists, and start is accepted only when unlock=1 in IDLE. Between reset and the first unlocked completion, ptext stays 16'h0000. Dropping unlock mid-operation does not abort; the operation completes normally.
- Undefined: the unlock port is absent and start is accepted unconditionally.

Decomposition:
- Package aes16_pkg holds:
  - functions: inv_sbox4, sbox4, gf16_mul2, gf16_mul9
  - constants: RCON1=8'h80, RCON2=8'h30
  - FSM state encoding typedef: IDLE, KEYX, RND2, RND1, FIN
- Sub-module aes16_key_expand: combinational, key[15:0] -> K0, K1, K2. Instantiated once and registered in KEYX.
- The round datapath stays inline in the core.

Test Plan:
- Reset asserted, then released -> ptext=16'h0000, done=0, busy=0; no done pulse over 20 idle cycles.
- ctext=16'h0738, key=16'hA73B, start pulse -> busy for 4 cycles, then done pulse with ptext=16'h6F6B exactly 4 cycles after the start edge.
- ctext=16'h24EC, key=16'h4AF5 -> ptext=16'hD728.
- Start issued 1 and 2 cycles after the first start with ctext=16'hFFFF -> ignored; one done pulse only, ptext=16'h6F6B.
- Reset asserted at RND1 mid-operation -> state IDLE, ptext=0, no done pulse. A subsequent 0x0738/A73B request completes correctly.
- Back-to-back: start re-asserted during the done cycle with 0x24EC/4AF5 -> second done 5 cycles after the first, ptext=16'hD728.
- With AES_DECR_LOCK_EN: unlock=0 and start -> no busy, no done. unlock=1 and start -> ptext=16'h6F6B.
